// File: rtl/branch_pc_unit.sv
// Program counter and branch resolution for the 16-bit pipeline: next fetch
// address selection, IF/ID flush, stall hold, halt and taken-redirect counter.
module branch_pc_unit #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [1:0]      branch,
    input  logic [PC_W-1:0] id_pc,
    input  logic [PC_W-1:0] br_offset,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            halt,
    output logic [PC_W-1:0] pc,
    output logic            if_flush,
    output logic            redirect,
    output logic            halted,
    output logic            bad_branch,
    output logic [PC_W-1:0] taken_count
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_HALTED   = 2'd2
    } state_e;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [PC_W-1:0] PC_MAX = {PC_W{1'b1}};

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] taken_count_q, taken_count_d;
    logic            redirect_q, redirect_d;
    logic            halted_q, halted_d;
    logic            bad_branch_q, bad_branch_d;
    logic            accept_s;

    function automatic logic [PC_W-1:0] sat_inc(input logic [PC_W-1:0] v);
        return (v == PC_MAX) ? v : v + PC_ONE;
    endfunction

    // A redirect is taken only from RUN with the pipeline moving; this is also the flush.
    always_comb begin
        accept_s = (state_q == ST_RUN) && !stall &&
                   ((branch == 2'b01) || (branch == 2'b10));
    end

    assign if_flush = accept_s;

    // Next-state, next-PC and counter selection.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        taken_count_d = taken_count_q;
        bad_branch_d  = bad_branch_q;
        case (state_q)
            ST_RUN: begin
                if (stall) begin
                    pc_d = pc_q;
                end else begin
                    case (branch)
                        2'b01: begin
                            pc_d          = id_pc + PC_ONE + br_offset;
                            state_d       = ST_REDIRECT;
                            taken_count_d = sat_inc(taken_count_q);
                        end
                        2'b10: begin
                            pc_d          = jmp_target;
                            state_d       = ST_REDIRECT;
                            taken_count_d = sat_inc(taken_count_q);
                        end
                        default: begin
                            // Reserved encoding falls through as not-taken but is latched.
                            if (branch == 2'b11) begin
                                bad_branch_d = 1'b1;
                            end else begin
                                bad_branch_d = bad_branch_q;
                            end
                            if (halt) begin
                                state_d = ST_HALTED;
                            end else begin
                                pc_d = pc_q + PC_ONE;
                            end
                        end
                    endcase
                end
            end
            ST_REDIRECT: begin
                // ID holds the squashed bubble, so branch and halt are meaningless here.
                if (stall) begin
                    pc_d = pc_q;
                end else begin
                    pc_d    = pc_q + PC_ONE;
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                pc_d = pc_q;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        redirect_d = (state_d == ST_REDIRECT);
        halted_d   = (state_d == ST_HALTED);
    end

    // State and registered outputs, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            taken_count_q <= {PC_W{1'b0}};
            redirect_q    <= 1'b0;
            halted_q      <= 1'b0;
            bad_branch_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            taken_count_q <= taken_count_d;
            redirect_q    <= redirect_d;
            halted_q      <= halted_d;
            bad_branch_q  <= bad_branch_d;
        end
    end

    assign pc          = pc_q;
    assign taken_count = taken_count_q;
    assign redirect    = redirect_q;
    assign halted      = halted_q;
    assign bad_branch  = bad_branch_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_branch_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [1:0]  branch;
    logic [15:0] id_pc;
    logic [15:0] br_offset;
    logic [15:0] jmp_target;
    logic        halt;
    logic [15:0] pc;
    logic        if_flush;
    logic        redirect;
    logic        halted;
    logic        bad_branch;
    logic [15:0] taken_count;

    int n_cmp;
    int n_bad;

    // Reference model: architectural view of the unit.
    int m_pc;
    int m_cnt;
    bit m_in_redirect;
    bit m_stopped;
    bit m_bad;

    branch_pc_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch),
        .id_pc(id_pc), .br_offset(br_offset), .jmp_target(jmp_target),
        .halt(halt), .pc(pc), .if_flush(if_flush), .redirect(redirect),
        .halted(halted), .bad_branch(bad_branch), .taken_count(taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, check flush mid-cycle, advance model, check registers.
    task automatic cyc(input bit r, input bit s, input logic [1:0] b, input int ipc,
                       input int off, input int tgt, input bit h);
        bit take;
        rst = r; stall = s; branch = b; halt = h;
        id_pc = 16'(ipc); br_offset = 16'(off); jmp_target = 16'(tgt);
        take = r && !m_stopped && !m_in_redirect && !s && (b == 2'd1 || b == 2'd2);
        @(negedge clk);
        if (r) chk("if_flush", {31'd0, if_flush}, {31'd0, take});
        @(posedge clk);
        if (!r) begin
            m_pc = 0; m_cnt = 0; m_in_redirect = 0; m_stopped = 0; m_bad = 0;
        end else if (m_stopped) begin
            m_pc = m_pc;
        end else if (m_in_redirect) begin
            if (!s) begin
                m_pc = (m_pc + 1) % 65536;
                m_in_redirect = 0;
            end
        end else if (!s) begin
            if (take) begin
                m_pc = (b == 2'd1) ? (ipc + 1 + off) % 65536 : tgt;
                m_in_redirect = 1;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end else begin
                if (b == 2'd3) m_bad = 1;
                if (h) m_stopped = 1;
                else m_pc = (m_pc + 1) % 65536;
            end
        end
        #1;
        chk("pc", {16'd0, pc}, 32'(m_pc));
        chk("redirect", {31'd0, redirect}, {31'd0, m_in_redirect});
        chk("halted", {31'd0, halted}, {31'd0, m_stopped});
        chk("bad_branch", {31'd0, bad_branch}, {31'd0, m_bad});
        chk("taken_count", {16'd0, taken_count}, 32'(m_cnt));
    endtask

    task automatic step();
        cyc(1'b1, 1'b0, 2'd0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        m_pc = 0; m_cnt = 0; m_in_redirect = 0; m_stopped = 0; m_bad = 0;
        rst = 1'b0; stall = 1'b0; branch = 2'd0; halt = 1'b0;
        id_pc = 16'h0; br_offset = 16'h0; jmp_target = 16'h0;

        // Reset and free run: 0,1,2,3.
        cyc(1'b0, 1'b0, 2'd0, 0, 0, 0, 1'b0);
        chk("reset_pc", {16'd0, pc}, 32'h0);
        for (int i = 0; i < 3; i++) step();
        chk("free_run_pc3", {16'd0, pc}, 32'h3);
        while (m_pc != 8) step();

        // Relative branch backwards: 7 + 1 - 4 = 4.
        cyc(1'b1, 1'b0, 2'd1, 7, 16'hFFFC, 0, 1'b0);
        chk("rel_branch_pc", {16'd0, pc}, 32'h4);
        chk("rel_branch_redirect", {31'd0, redirect}, 32'h1);
        cyc(1'b1, 1'b0, 2'd1, 7, 16'hFFFC, 0, 1'b0);
        chk("redirect_ignores_branch_pc", {16'd0, pc}, 32'h5);
        chk("redirect_drops", {31'd0, redirect}, 32'h0);

        // Jump held off by stall for two cycles.
        cyc(1'b1, 1'b1, 2'd2, 0, 0, 16'h0040, 1'b0);
        cyc(1'b1, 1'b1, 2'd2, 0, 0, 16'h0040, 1'b0);
        chk("stall_hold_pc", {16'd0, pc}, 32'h5);
        cyc(1'b1, 1'b0, 2'd2, 0, 0, 16'h0040, 1'b0);
        chk("jump_pc", {16'd0, pc}, 32'h40);
        chk("jump_count", {16'd0, taken_count}, 32'h2);
        step();

        // Reserved branch encoding.
        cyc(1'b1, 1'b0, 2'd3, 0, 0, 0, 1'b0);
        chk("bad_branch_seq_pc", {16'd0, pc}, 32'h42);
        for (int i = 0; i < 3; i++) step();
        chk("bad_branch_sticky", {31'd0, bad_branch}, 32'h1);

        // Halt, then branches are ignored.
        cyc(1'b1, 1'b0, 2'd0, 0, 0, 0, 1'b1);
        chk("halted_set", {31'd0, halted}, 32'h1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 2'd1, 3, 3, 0, 1'b0);
        chk("halted_pc_frozen", {16'd0, pc}, 32'h45);
        cyc(1'b0, 1'b0, 2'd0, 0, 0, 0, 1'b0);
        chk("halt_reset_pc", {16'd0, pc}, 32'h0);
        chk("halt_reset_halted", {31'd0, halted}, 32'h0);

        // Wrap past the top of the address space.
        cyc(1'b1, 1'b0, 2'd2, 0, 0, 16'hFFFE, 1'b0);
        chk("wrap_start", {16'd0, pc}, 32'hFFFE);
        step(); step();
        chk("wrap_zero", {16'd0, pc}, 32'h0);
        step();
        chk("wrap_one", {16'd0, pc}, 32'h1);

        // Reset in the middle of a redirect.
        cyc(1'b1, 1'b0, 2'd2, 0, 0, 16'h1234, 1'b0);
        cyc(1'b0, 1'b1, 2'd1, 5, 5, 0, 1'b1);
        chk("mid_redirect_reset", {31'd0, redirect}, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(63) != 0),
                ($urandom_range(3) == 0),
                2'($urandom_range(3)),
                int'($urandom_range(65535)),
                int'($urandom_range(65535)),
                int'($urandom_range(65535)),
                ($urandom_range(24) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
